// File: rtl/mem_commutator_xbar.sv
// mem_commutator_xbar: NM-master x NS-slave memory commutator.
// Every slave owns a round-robin arbiter with a registered grant, so
// transfers to different slaves run in parallel. Requests whose slave
// select is >= NS get a one-cycle error response from a per-master register.
// Optional feature macro: MEM_COMM_TIMEOUT_EN adds a per-slave watchdog that
// ends a stalled transfer with an error response carrying 32'hDEAD_BEEF.
module mem_commutator_xbar #(
    parameter int NM      = 3,
    parameter int NS      = 4,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int SW      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*AW-1:0] m_addr_i,
    input  logic [NM*DW-1:0] m_data_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NM*DW-1:0] m_data_o,
    output logic [NS-1:0]    s_stb_o,
    output logic [NS-1:0]    s_we_o,
    output logic [NS*AW-1:0] s_addr_o,
    output logic [NS*DW-1:0] s_data_o,
    input  logic [NS-1:0]    s_ack_i,
    input  logic [NS*DW-1:0] s_data_i
);
    localparam int GW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [SW-1:0] sel [NM];
    logic [NM-1:0] dec_err;
    logic [NM-1:0] err_q;

    logic [NS-1:0] rsp_vld;
    logic [NS-1:0] rsp_err;
    logic [GW-1:0] rsp_gnt  [NS];
    logic [DW-1:0] rsp_data [NS];

    // Slave-select decode of every master address
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            sel[i]     = m_addr_i[i*AW+AW-1 -: SW];
            dec_err[i] = (int'(sel[i]) >= NS);
        end
    end

    // Decode-error responder: exactly one ack cycle per unmapped request
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) err_q <= '0;
        else          err_q <= m_stb_i & dec_err & ~err_q;
    end

    for (genvar gs = 0; gs < NS; gs++) begin : g_slv
        state_t        state_q, state_d;
        logic [GW-1:0] grant_q, grant_d;
        logic [GW-1:0] rr_q, rr_d;
        logic [GW-1:0] pick;
        logic [NM-1:0] req;
        logic          any_req, g_stb, tmo, ack_ok;
        logic          o_stb, o_we;
        logic [AW-1:0] o_addr;
        logic [DW-1:0] o_data;

        // Masters currently addressing this slave
        always_comb begin
            for (int i = 0; i < NM; i++)
                req[i] = m_stb_i[i] && !dec_err[i] && (sel[i] == SW'(gs));
        end

        assign any_req = |req;
        assign g_stb   = m_stb_i[grant_q];

        // Round-robin pick: first requester at or after rr_q, cyclically
        always_comb begin : p_pick
            int idx;
            idx  = 0;
            pick = rr_q;
            for (int k = NM - 1; k >= 0; k--) begin
                idx = (int'(rr_q) + k) % NM;
                if (req[idx]) pick = GW'(idx);
            end
        end

`ifdef MEM_COMM_TIMEOUT_EN
        logic [15:0] cnt_q;

        assign tmo = (state_q == BUSY) && g_stb && (cnt_q == 16'(TIMEOUT));

        // Watchdog: BUSY cycles elapsed since the grant, zero while IDLE
        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst)              cnt_q <= '0;
            else if (state_q == IDLE)  cnt_q <= '0;
            else                       cnt_q <= cnt_q + 16'd1;
        end
`else
        assign tmo = 1'b0;
`endif

        // A timed-out transfer ignores a late slave ack
        assign ack_ok = (state_q == BUSY) && g_stb && s_ack_i[gs] && !tmo;

        // State register with grant and round-robin pointer
        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                state_q <= IDLE;
                grant_q <= '0;
                rr_q    <= '0;
            end else begin
                state_q <= state_d;
                grant_q <= grant_d;
                rr_q    <= rr_d;
            end
        end

        // Next state: grant from IDLE; completion, timeout or abandonment from BUSY
        always_comb begin
            state_d = state_q;
            grant_d = grant_q;
            rr_d    = rr_q;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_d = BUSY;
                        grant_d = pick;
                    end
                end
                BUSY: begin
                    if (!g_stb) begin
                        // master gave up: no ack, pointer untouched
                        state_d = IDLE;
                    end else if (ack_ok || tmo) begin
                        state_d = IDLE;
                        rr_d    = (grant_q == GW'(NM - 1)) ? '0 : grant_q + GW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Slave-side outputs: granted master muxed through only while BUSY
        always_comb begin
            o_stb  = 1'b0;
            o_we   = 1'b0;
            o_addr = '0;
            o_data = '0;
            if (state_q == BUSY) begin
                o_stb  = g_stb && !tmo;
                o_we   = m_we_i[grant_q];
                o_addr = m_addr_i[int'(grant_q)*AW +: AW];
                o_data = m_data_i[int'(grant_q)*DW +: DW];
            end
        end

        assign s_stb_o[gs]            = o_stb;
        assign s_we_o[gs]             = o_we;
        assign s_addr_o[gs*AW +: AW]  = o_addr;
        assign s_data_o[gs*DW +: DW]  = o_data;

        assign rsp_vld[gs]  = ack_ok || tmo;
        assign rsp_err[gs]  = tmo;
        assign rsp_gnt[gs]  = grant_q;
        assign rsp_data[gs] = tmo ? DW'(32'hDEAD_BEEF) : s_data_i[gs*DW +: DW];
    end

    // Route slave and decode-error responses back to their masters
    always_comb begin
        m_ack_o  = err_q;
        m_err_o  = err_q;
        m_data_o = '0;
        for (int s = 0; s < NS; s++) begin
            if (rsp_vld[s]) begin
                m_ack_o[rsp_gnt[s]]                 = 1'b1;
                m_err_o[rsp_gnt[s]]                 = rsp_err[s];
                m_data_o[int'(rsp_gnt[s])*DW +: DW] = rsp_data[s];
            end
        end
    end

endmodule

// File: tb/tb_mem_commutator_xbar.sv
// Scoreboard bench for mem_commutator_xbar: expected master responses are
// queued when a request is issued and popped when the DUT acknowledges.
// A second instance with NS=3 exercises the decode-error path.
module tb_mem_commutator_xbar;
    localparam int NM = 3, NS = 4, AW = 16, DW = 32, SW = 2, TMO = 8;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [NM-1:0]    m_stb, m_we, m_ack, m_err;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_data, m_rdata;
    logic [NS-1:0]    s_stb, s_we, s_ack;
    logic [NS*AW-1:0] s_addr;
    logic [NS*DW-1:0] s_wdata, s_rdata;

    logic [NM-1:0]    e_m_ack, e_m_err;
    logic [NM*DW-1:0] e_m_rdata;
    logic [2:0]       e_s_stb, e_s_we;
    logic [2:0]       e_s_ack = '0;
    logic [3*AW-1:0]  e_s_addr;
    logic [3*DW-1:0]  e_s_wdata;
    logic [3*DW-1:0]  e_s_rdata = '0;

    logic [NS-1:0]    ack_imm, ack_frc;
    logic [DW-1:0]    dat_frc [NS];
    logic [32:0]      exp_q [NM][$];
    int               order [4] = '{0, 1, 2, 0};
    int               n_chk = 0;
    int               n_err = 0;

    always #5 sys_clk = ~sys_clk;

    mem_commutator_xbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TMO)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_stb_i(m_stb), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_data),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_data_o(m_rdata),
        .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_wdata),
        .s_ack_i(s_ack), .s_data_i(s_rdata)
    );

    mem_commutator_xbar #(.NM(NM), .NS(3), .AW(AW), .DW(DW), .SW(SW)) u_err (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_stb_i(m_stb), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_data),
        .m_ack_o(e_m_ack), .m_err_o(e_m_err), .m_data_o(e_m_rdata),
        .s_stb_o(e_s_stb), .s_we_o(e_s_we), .s_addr_o(e_s_addr), .s_data_o(e_s_wdata),
        .s_ack_i(e_s_ack), .s_data_i(e_s_rdata)
    );

    // Slave models: immediate ack with address-tagged data, or forced ack/data
    for (genvar g = 0; g < NS; g++) begin : g_slave
        assign s_ack[g]           = (ack_imm[g] & s_stb[g]) | ack_frc[g];
        assign s_rdata[g*DW +: DW] = ack_imm[g] ? {16'hA500, s_addr[g*AW +: AW]} : dat_frc[g];
    end

    function automatic logic [31:0] imm_dat(input logic [15:0] a);
        return {16'hA500, a};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge sys_clk);
    endtask

    task automatic req(input int i, input logic [15:0] a, input logic we, input logic [31:0] d);
        m_stb[i]           = 1'b1;
        m_we[i]            = we;
        m_addr[i*AW +: AW] = a;
        m_data[i*DW +: DW] = d;
    endtask

    task automatic drop(input int i);
        m_stb[i] = 1'b0;
        m_we[i]  = 1'b0;
    endtask

    task automatic expect_rsp(input int i, input logic err, input logic [31:0] d);
        exp_q[i].push_back({err, d});
    endtask

    // Scoreboard monitor on the main instance
    always @(negedge sys_clk) begin : mon
        logic [32:0] e;
        if (sys_rst) begin
            for (int i = 0; i < NM; i++) begin
                if (m_ack[i]) begin
                    check_val($sformatf("sb_pending_m%0d", i), 64'(exp_q[i].size() != 0), 64'd1);
                    if (exp_q[i].size() != 0) begin
                        e = exp_q[i].pop_front();
                        check_val($sformatf("rsp_m%0d", i), 64'({m_err[i], m_rdata[i*DW +: DW]}), 64'(e));
                    end
                end else begin
                    check_val($sformatf("quiet_m%0d", i), 64'({m_err[i], m_rdata[i*DW +: DW]}), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_ack;
        sys_rst = 1'b0;
        m_stb = '0; m_we = '0; m_addr = '0; m_data = '0;
        ack_imm = '0; ack_frc = '0;
        for (int s = 0; s < NS; s++) dat_frc[s] = '0;

        // reset state
        smp();
        check_val("rst_ctrl", 64'({s_stb, s_we, m_ack, m_err}), 64'd0);
        check_val("rst_addr", 64'(s_addr), 64'd0);
        check_val("rst_data", 64'({|s_wdata, |m_rdata}), 64'd0);
        check_val("rst_err_inst", 64'({e_s_stb, e_s_we, |e_s_addr, |e_s_wdata, e_m_ack, e_m_err, |e_m_rdata}), 64'd0);
        nxt(); nxt();
        sys_rst = 1'b1;

        // single read, slave acks two cycles after s_stb
        req(0, 16'h0004, 1'b0, 32'h0);
        expect_rsp(0, 1'b0, 32'h1234_5678);
        smp(); check_val("t1_pre_stb", 64'(s_stb), 64'd0);
        nxt(); smp();
        check_val("t1_stb", 64'(s_stb), 64'b0001);
        check_val("t1_addr", 64'(s_addr[15:0]), 64'h0004);
        check_val("t1_we", 64'(s_we), 64'd0);
        nxt(); smp(); check_val("t1_wait", 64'({s_stb, m_ack}), 64'({4'b0001, 3'b000}));
        nxt(); ack_frc[0] = 1'b1; dat_frc[0] = 32'h1234_5678;
        smp(); check_val("t1_ack", 64'({m_ack, m_err}), 64'({3'b001, 3'b000}));
        nxt(); ack_frc[0] = 1'b0; drop(0);
        smp(); check_val("t1_idle", 64'(s_stb), 64'd0);
        nxt();

        // contention on slave 1: order 0,1,2,0 with a bubble between
        ack_imm[1] = 1'b1;
        req(0, 16'h4000, 1'b0, 32'h0);
        req(1, 16'h4004, 1'b0, 32'h0);
        req(2, 16'h4008, 1'b0, 32'h0);
        expect_rsp(0, 1'b0, imm_dat(16'h4000));
        expect_rsp(1, 1'b0, imm_dat(16'h4004));
        expect_rsp(2, 1'b0, imm_dat(16'h4008));
        expect_rsp(0, 1'b0, imm_dat(16'h4000));
        smp(); check_val("t2_pre_stb", 64'(s_stb), 64'd0);
        for (int c = 1; c <= 8; c++) begin
            nxt();
            if (c == 8) begin drop(0); drop(1); drop(2); end
            smp();
            exp_ack = (c % 2 == 1) ? (3'b001 << order[(c-1)/2]) : 3'b000;
            check_val($sformatf("t2_ack_c%0d", c), 64'(m_ack), 64'(exp_ack));
            check_val($sformatf("t2_stb_c%0d", c), 64'(s_stb[1]), 64'(c % 2));
        end
        nxt();

        // parallel: m1 reads slave 1 while m2 writes slave 3
        ack_imm[3] = 1'b1;
        req(1, 16'h4000, 1'b0, 32'h0);
        req(2, 16'hC010, 1'b1, 32'hCAFE_0001);
        expect_rsp(1, 1'b0, imm_dat(16'h4000));
        expect_rsp(2, 1'b0, imm_dat(16'hC010));
        smp();
        nxt(); smp();
        check_val("t3_stb", 64'(s_stb), 64'b1010);
        check_val("t3_we", 64'(s_we), 64'b1000);
        check_val("t3_wdata3", 64'(s_wdata[3*DW +: DW]), 64'hCAFE_0001);
        check_val("t3_addr3", 64'(s_addr[3*AW +: AW]), 64'hC010);
        check_val("t3_ack", 64'(m_ack), 64'b110);
        nxt(); drop(1); drop(2);
        smp(); check_val("t3_idle", 64'(s_stb), 64'd0);
        nxt();

        // decode error on the NS=3 instance, held stb reissues after the ack
        req(1, 16'hC000, 1'b0, 32'h0);
        expect_rsp(1, 1'b0, imm_dat(16'hC000));
        expect_rsp(1, 1'b0, imm_dat(16'hC000));
        smp(); check_val("t4_e_ack0", 64'(e_m_ack), 64'd0);
        nxt(); smp();
        check_val("t4_e_ack1", 64'({e_m_ack, e_m_err}), 64'({3'b010, 3'b010}));
        check_val("t4_e_data", 64'(e_m_rdata[DW +: DW]), 64'd0);
        check_val("t4_e_sstb", 64'(e_s_stb), 64'd0);
        nxt(); smp(); check_val("t4_e_ack2", 64'({e_m_ack, e_m_err}), 64'd0);
        nxt(); smp(); check_val("t4_e_ack3", 64'({e_m_ack, e_m_err}), 64'({3'b010, 3'b010}));
        nxt(); drop(1);
        smp(); check_val("t4_e_ack4", 64'(e_m_ack), 64'd0);
        nxt();

        // silent slave 2: watchdog response or permanent stall
        ack_imm[2] = 1'b0;
        req(0, 16'h8000, 1'b0, 32'h0);
        req(1, 16'h8004, 1'b0, 32'h0);
        smp();
`ifdef MEM_COMM_TIMEOUT_EN
        expect_rsp(0, 1'b1, 32'hDEAD_BEEF);
        expect_rsp(1, 1'b0, 32'h5555_AAAA);
        for (int c = 1; c <= 9; c++) begin
            nxt(); smp();
            if (c < 9) check_val($sformatf("t5_busy_c%0d", c), 64'({s_stb[2], m_ack}), 64'({1'b1, 3'b000}));
            else       check_val("t5_tmo", 64'({s_stb[2], m_ack, m_err}), 64'({1'b0, 3'b001, 3'b001}));
        end
        nxt(); drop(0);
        smp(); check_val("t5_bubble", 64'(s_stb[2]), 64'd0);
`else
        expect_rsp(1, 1'b0, 32'h5555_AAAA);
        for (int c = 1; c <= 20; c++) begin
            nxt(); smp();
            check_val($sformatf("t5_stall_c%0d", c), 64'({s_stb[2], m_ack}), 64'({1'b1, 3'b000}));
        end
        check_val("t5_stall_addr", 64'(s_addr[2*AW +: AW]), 64'h8000);
        nxt(); drop(0);
        smp(); check_val("t5_abort", 64'({s_stb[2], m_ack}), 64'd0);
        nxt(); smp(); check_val("t5_bubble", 64'(s_stb[2]), 64'd0);
`endif
        nxt(); ack_frc[2] = 1'b1; dat_frc[2] = 32'h5555_AAAA;
        smp();
        check_val("t5_next_stb", 64'(s_stb[2]), 64'd1);
        check_val("t5_next_addr", 64'(s_addr[2*AW +: AW]), 64'h8004);
        check_val("t5_next_ack", 64'(m_ack), 64'b010);
        nxt(); drop(1); ack_frc[2] = 1'b0;
        smp();
        nxt();

        // reset while BUSY for master 1; afterwards master 0 wins (rr back to 0)
        ack_imm[0] = 1'b0;
        req(1, 16'h0010, 1'b0, 32'h0);
        smp();
        nxt(); smp();
        check_val("t6_busy", 64'(s_stb[0]), 64'd1);
        #2 sys_rst = 1'b0;
        #1;
        check_val("t6_async_ctrl", 64'({s_stb, s_we, m_ack, m_err}), 64'd0);
        check_val("t6_async_addr", 64'(s_addr), 64'd0);
        check_val("t6_async_data", 64'({|s_wdata, |m_rdata}), 64'd0);
        nxt();
        req(0, 16'h000C, 1'b0, 32'h0);
        req(1, 16'h0010, 1'b0, 32'h0);
        ack_imm[0] = 1'b1;
        sys_rst = 1'b1;
        expect_rsp(0, 1'b0, imm_dat(16'h000C));
        expect_rsp(1, 1'b0, imm_dat(16'h0010));
        smp(); check_val("t6_post_idle", 64'(s_stb), 64'd0);
        nxt(); smp();
        check_val("t6_first_addr", 64'(s_addr[15:0]), 64'h000C);
        check_val("t6_first_ack", 64'(m_ack), 64'b001);
        nxt(); drop(0);
        smp(); check_val("t6_bubble", 64'(s_stb[0]), 64'd0);
        nxt(); smp();
        check_val("t6_second_addr", 64'(s_addr[15:0]), 64'h0010);
        check_val("t6_second_ack", 64'(m_ack), 64'b010);
        nxt(); drop(1);
        smp();
        nxt();

        for (int i = 0; i < NM; i++)
            check_val($sformatf("sb_left_m%0d", i), 64'(exp_q[i].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_commutator_xbar.md
# mem_commutator_xbar

Parametrised N-master × M-slave memory commutator, the next generation of the fixed three-master memory switch. It sits between the CPU instruction port, the CPU data port, DMA and further masters on one side, and RAM ports, ROM, IO and other slaves on the other. Each slave has its own round-robin arbiter with a registered grant, so transactions to different slaves proceed in parallel. Requests to unmapped addresses complete with an error response.

## Interface
- NM, 3: number of masters (index 0 = cpu_inst, 1 = cpu_data, 2 = dma).
- NS, 4: number of slaves, 1..2^SW.
- AW, 16: address width.
- DW, 32: data width.
- SW, 2: slave-select width. Slave index = addr[AW-1 -: SW].
- TIMEOUT, 255: watchdog limit in cycles, range 1..65535.
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- m_stb_i  in  NM  per-master request strobe.
- m_we_i  in  NM  per-master write enable.
- m_addr_i  in  NM*AW  flattened master addresses; master i in [i*AW +: AW].
- m_data_i  in  NM*DW  flattened master write data.
- m_ack_o  out  NM  per-master acknowledge.
- m_err_o  out  NM  per-master error, valid with m_ack_o.
- m_data_o  out  NM*DW  per-master read data, valid with m_ack_o.
- s_stb_o  out  NS  per-slave strobe.
- s_we_o  out  NS  per-slave write enable.
- s_addr_o  out  NS*AW  per-slave address; the full address is passed through.
- s_data_o  out  NS*DW  per-slave write data.
- s_ack_i  in  NS  per-slave acknowledge.
- s_data_i  in  NS*DW  per-slave read data.

## Operation
- Master protocol: the master holds stb, we, addr and data stable until it samples ack=1. One outstanding transaction per master.
- Decode: sel = addr[AW-1 -: SW]. If sel >= NS, the request goes to the error path.
- Per-slave FSM:
  - IDLE: if any master requests this slave, register grant = first requester at or after rr_ptr, cyclically. Go to BUSY.
  - BUSY: s_stb_o = granted master's stb. s_we/addr/data are muxed from the granted master.
  - BUSY, s_ack_i=1: route ack and data to the granted master combinationally in the same cycle. Set rr_ptr = grant+1 mod NM. Go to IDLE.
  - BUSY, granted master drops stb before ack (protocol violation): s_stb_o falls in the same cycle. Go to IDLE, no ack, rr_ptr unchanged.
- Non-granted masters see m_ack_o=0 and keep waiting.
- Error path: a per-master 1-bit register. A request with sel >= NS gets m_ack_o=1, m_err_o=1, m_data_o=0 one cycle after stb is sampled, for exactly one cycle.
- Output muxing:
  - m_data_o = 0 when m_ack_o=0.
  - m_err_o = 0 except when an error response is being returned.
  - A slave that is not in BUSY drives s_stb_o=0, s_we_o=0, s_addr_o=0, s_data_o=0.
- Parallelism: masters addressing different slaves are served concurrently with no mutual stall.
- Reset values: all s_stb_o, s_we_o, m_ack_o, m_err_o = 0; all address/data outputs = 0; all FSMs IDLE; all rr_ptr = 0; error registers = 0. Reset mid-transaction drops it silently; masters must reissue.

## Timing
- Stb sampled high at edge N: grant registered at N; s_stb_o high during cycle N+1.
- Slave ack in cycle K: m_ack_o high in cycle K, FSM IDLE at K+1. Earliest re-grant of that slave is at edge K+1, so s_stb_o is high again in cycle K+2 (one bubble per transaction).
- Minimum latency stb to ack = 1 cycle plus slave latency.
- Error response latency = 1 cycle.
- Back-to-back: a master that reasserts stb in the cycle after its ack is treated as a new request.
- Fairness: with all NM masters continuously requesting one slave, each is served once per NM transactions.
- Simultaneous ack and a new request from another master in the same cycle: the new request is granted at the next edge, arbitrated with the already-advanced rr_ptr.

## Configuration
- MEM_COMM_TIMEOUT_EN defined:
  - Per-slave 16-bit counter, cleared on entry to BUSY, incremented each BUSY cycle without ack.
  - On reaching TIMEOUT: drive m_ack_o=1, m_err_o=1, m_data_o=32'hDEAD_BEEF to the granted master for one cycle; deassert s_stb_o; go to IDLE; advance rr_ptr.
  - A late ack from the slave is ignored.
- MEM_COMM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for s_ack_i; m_err_o is asserted only on the decode-error path.

## Test plan
- Single read: master 0 reads 0x0004 (slave 0), slave acks with 32'h1234_5678 two cycles after s_stb_o -> s_stb_o[0] high from N+1, m_ack_o[0] and data 32'h1234_5678 in the slave-ack cycle, m_err_o=0.
- Contention: masters 0, 1 and 2 all request slave 1 continuously, slave acks immediately -> grant order 0,1,2,0, with one bubble cycle between transactions.
- Parallel: master 1 requests 0x4000 (slave 1) while master 2 writes 32'hCAFE_0001 to 0xC010 (slave 3) -> both s_stb_o high in the same cycle; s_we_o[3]=1, s_data_o[3]=32'hCAFE_0001.
- Decode error with NS=3: master 1 requests 0xC000 -> m_ack_o[1]=1, m_err_o[1]=1, m_data_o=0 one cycle later; no s_stb_o asserted.
- Timeout with MEM_COMM_TIMEOUT_EN and TIMEOUT=8: slave 2 never acks -> after 8 BUSY cycles m_err_o=1 and data 32'hDEAD_BEEF; the slave is free for the next master. Without the macro, the bench must instead see a permanent stall with no ack.
- Reset in BUSY: assert sys_rst=0 while s_stb_o[0]=1 -> all outputs 0 asynchronously; after release, a new request is granted to master 0 first (rr_ptr=0).
